// File: rtl/tinyalu_core.sv
// TinyALU core: single-cycle add/and/xor, multi-cycle multiply, one-cycle done pulse.
// Operands are latched on accept; result is registered and held between completions.
module tinyalu_core #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] NO_OP  = 3'b000;
  localparam logic [2:0] ADD_OP = 3'b001;
  localparam logic [2:0] AND_OP = 3'b010;
  localparam logic [2:0] XOR_OP = 3'b011;
  localparam logic [2:0] MUL_OP = 3'b100;
  localparam logic [2:0] RST_OP = 3'b111;

  localparam logic [2:0] CNT_LOAD = 3'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [15:0] mul_w;
  logic [8:0]  sum_w;

  assign sum_w = {1'b0, A} + {1'b0, B};
  // Product of the latched operands; settles over the MUL_WAIT cycles.
  assign mul_w = {8'b0, a_q} * {8'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = A;
          b_d = B;
          case (op)
            ADD_OP: begin
              result_d = {7'b0, sum_w};
              state_d  = DONE;
            end
            AND_OP: begin
              result_d = {8'b0, A & B};
              state_d  = DONE;
            end
            XOR_OP: begin
              result_d = {8'b0, A ^ B};
              state_d  = DONE;
            end
            MUL_OP: begin
              cnt_d   = CNT_LOAD;
              state_d = MUL_WAIT;
            end
            RST_OP: begin
              result_d = 16'h0000;
            end
            NO_OP:   state_d = DONE;
            default: state_d = DONE;
          endcase
        end
      end
      MUL_WAIT: begin
        if (cnt_q == 3'd1) begin
          result_d = mul_w;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      // Single-cycle ops resolve on the accept edge, so EXEC is never entered.
      default: state_d = IDLE;
    endcase
  end

  assign done   = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign result = result_q;

endmodule
